// File: rtl/store_capture_pkg.sv
// store_capture_pkg
//   Shared defaults and the FIFO entry type for the store_capture block.
//   Optional feature macro: STORE_CAPTURE_TIMESTAMP_EN. When it is defined,
//   every entry also carries the cycle count at the moment of the push.
package store_capture_pkg;

  localparam int          N_DEF            = 16;
  localparam int          DEPTH_DEF        = 8;
  localparam logic [15:0] CAPTURE_ADDR_DEF = 16'h0040;
  localparam logic [15:0] HALT_ADDR_DEF    = 16'h00FE;

  // Default entry layout, used when the FIFO is built at the default width.
  typedef struct packed {
    logic [N_DEF-1:0] data;
`ifdef STORE_CAPTURE_TIMESTAMP_EN
    logic [N_DEF-1:0] time_stamp;
`endif
  } capture_entry_t;

endpackage

// File: rtl/store_fifo.sv
// store_fifo
//   Synchronous FIFO with a registered head. The head register always holds
//   the oldest entry while the FIFO is non-empty, so the consumer sees
//   registered data with one cycle of push-to-head latency and no bypass.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   push            request to enqueue push_entry this edge
//   push_entry      entry to enqueue
//   pop_req         consumer ready; ignored while empty
//   head            registered oldest entry (holds last value when empty)
//   empty           no entries stored
//   count           current occupancy, 0..DEPTH
//   push_accepted   the push was taken (not full, or a pop frees a slot)
module store_fifo
  import store_capture_pkg::*;
#(
  parameter type entry_t = capture_entry_t,
  parameter int  DEPTH   = DEPTH_DEF,
  localparam int AW      = $clog2(DEPTH),
  localparam int CW      = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  entry_t        push_entry,
  input  logic          pop_req,
  output entry_t        head,
  output logic          empty,
  output logic [CW-1:0] count,
  output logic          push_accepted
);

  entry_t        mem [DEPTH];
  entry_t        head_q;
  entry_t        head_next;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_next;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_next;
  logic          full;
  logic          pop;

  assign empty         = (count_q == '0);
  assign full          = (count_q == CW'(DEPTH));
  assign pop           = pop_req & ~empty;
  // When full, a same-edge pop frees the slot the push needs.
  assign push_accepted = push & (~full | pop);
  assign rd_next       = pop ? rd_ptr + AW'(1) : rd_ptr;

  always_comb begin
    count_next = count_q;
    case ({push_accepted, pop})
      2'b10:   count_next = count_q + CW'(1);
      2'b01:   count_next = count_q - CW'(1);
      default: count_next = count_q;
    endcase

    // The new head either already sits in memory or is being written on this
    // very edge (the FIFO was empty, or drains to the slot being filled).
    head_next = head_q;
    if (count_next != '0) begin
      if (push_accepted && (wr_ptr == rd_next)) begin
        head_next = push_entry;
      end else begin
        head_next = mem[rd_next];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      head_q  <= '0;
    end else begin
      if (push_accepted) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      rd_ptr  <= rd_next;
      count_q <= count_next;
      head_q  <= head_next;
    end
  end

  // Storage is not reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (!reset && push_accepted) begin
      mem[wr_ptr] <= push_entry;
    end
  end

  assign head  = head_q;
  assign count = count_q;

endmodule

// File: rtl/store_capture.sv
// store_capture
//   Snoops the store bus of the single-cycle MIPS `computer`. Stores to
//   CAPTURE_ADDR are queued and streamed out; the first store to HALT_ADDR
//   raises a sticky done and latches its data as an exit code.
//   Optional feature macro: STORE_CAPTURE_TIMESTAMP_EN adds a free-running
//   cycle counter, a per-entry timestamp (out_time) and halt_time.
// Handshake: out_valid/out_ready. A transfer happens on a posedge where
//   out_valid & out_ready are both high; out_data (and out_time) stay stable
//   while out_valid & !out_ready; out_ready is ignored while out_valid is low.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   memwrite        store strobe
//   dataadr         store byte address
//   writedata       store data
//   out_valid       head entry valid
//   out_ready       consumer accepts head
//   out_data        head data
//   count           occupancy
//   dropped         saturating count of pushes lost to a full FIFO
//   done            sticky halt flag
//   exit_code       data of the first halt store
//   out_time        (macro only) push-time cycle count of head entry
//   halt_time       (macro only) cycle count of the first halt store
module store_capture
  import store_capture_pkg::*;
#(
  parameter int          N            = N_DEF,
  parameter int          DEPTH        = DEPTH_DEF,
  parameter logic [N-1:0] CAPTURE_ADDR = N'(CAPTURE_ADDR_DEF),
  parameter logic [N-1:0] HALT_ADDR    = N'(HALT_ADDR_DEF)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   memwrite,
  input  logic [N-1:0]           dataadr,
  input  logic [N-1:0]           writedata,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [N-1:0]           out_data,
  output logic [$clog2(DEPTH):0] count,
  output logic [N-1:0]           dropped,
  output logic                   done,
  output logic [N-1:0]           exit_code
`ifdef STORE_CAPTURE_TIMESTAMP_EN
  ,
  output logic [N-1:0]           out_time,
  output logic [N-1:0]           halt_time
`endif
);

  // Same layout as capture_entry_t, but sized by this instance's N.
  typedef struct packed {
    logic [N-1:0] data;
`ifdef STORE_CAPTURE_TIMESTAMP_EN
    logic [N-1:0] time_stamp;
`endif
  } entry_t;

  logic   push;
  logic   halt;
  logic   push_accepted;
  logic   empty;
  entry_t push_entry;
  entry_t head;

  // Full-width compares; the two decodes are independent so an overlapping
  // address both pushes and halts.
  assign push = memwrite & (dataadr == CAPTURE_ADDR);
  assign halt = memwrite & (dataadr == HALT_ADDR);

`ifdef STORE_CAPTURE_TIMESTAMP_EN
  logic [N-1:0] cycle;

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle <= '0;
    end else begin
      cycle <= cycle + N'(1);
    end
  end

  always_comb begin
    push_entry            = '0;
    push_entry.data       = writedata;
    push_entry.time_stamp = cycle;
  end
`else
  always_comb begin
    push_entry      = '0;
    push_entry.data = writedata;
  end
`endif

  store_fifo #(
    .entry_t (entry_t),
    .DEPTH   (DEPTH)
  ) u_fifo (
    .clk           (clk),
    .reset         (reset),
    .push          (push),
    .push_entry    (push_entry),
    .pop_req       (out_ready),
    .head          (head),
    .empty         (empty),
    .count         (count),
    .push_accepted (push_accepted)
  );

  assign out_valid = ~empty;
  assign out_data  = head.data;
`ifdef STORE_CAPTURE_TIMESTAMP_EN
  assign out_time  = head.time_stamp;
`endif

  // A push that the FIFO refused is a drop; the counter sticks at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      dropped <= '0;
    end else if (push && !push_accepted && (dropped != '1)) begin
      dropped <= dropped + N'(1);
    end
  end

  // Only the first halt store is recorded; done stays set until reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      done      <= 1'b0;
      exit_code <= '0;
`ifdef STORE_CAPTURE_TIMESTAMP_EN
      halt_time <= '0;
`endif
    end else if (halt && !done) begin
      done      <= 1'b1;
      exit_code <= writedata;
`ifdef STORE_CAPTURE_TIMESTAMP_EN
      halt_time <= cycle;
`endif
    end
  end

endmodule

// File: doc/store_capture.md
Name: store_capture

Overview:
- Memory-mapped store monitor downstream of the 16-bit single-cycle MIPS `computer`.
- Snoops the `memwrite`/`dataadr`/`writedata` bus.
- Stores to CAPTURE_ADDR are buffered in a FIFO and drained over a valid/ready stream to a consumer (bench, UART, LED driver).
- A store to HALT_ADDR raises a sticky `done` and latches an exit code, giving benches a clean program-completion signal.

Parameters:
- N, 16, data and address width in bits.
- DEPTH, 8, FIFO entries; power of 2, minimum 2.
- CAPTURE_ADDR, 16'h0040, store address whose data is pushed to the FIFO.
- HALT_ADDR, 16'h00FE, store address that sets `done`.

Ports:
- clk  in  1  system clock, same clock as `computer`.
- reset  in  1  synchronous, active-high; sampled on posedge clk.
- memwrite  in  1  store strobe from `computer`.
- dataadr  in  N  store byte address.
- writedata  in  N  store data.
- out_valid  out  1  FIFO head is valid.
- out_ready  in  1  consumer accepts the head.
- out_data  out  N  FIFO head data.
- count  out  $clog2(DEPTH)+1  current occupancy.
- dropped  out  N  saturating count of stores lost to a full FIFO.
- done  out  1  sticky; a HALT_ADDR store has occurred.
- exit_code  out  N  `writedata` of the first HALT_ADDR store.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: out_valid=0, out_data=0, count=0, dropped=0, done=0, exit_code=0; read and write pointers =0.
  - Reset mid-operation discards all FIFO contents and the done state.
  - Reset wins over a simultaneous store.
- Bus sampling: sampled at posedge clk, the same edge on which `computer` commits the store.
  - push = memwrite & (dataadr == CAPTURE_ADDR).
  - halt = memwrite & (dataadr == HALT_ADDR).
  - Full address compare; no masking.
- Push latency: data pushed at edge k is visible as out_valid=1 / out_data after edge k (one-cycle latency), provided the FIFO was empty.
- Pop: occurs at a posedge where out_valid & out_ready.
  - out_data is registered from the head entry and updates on that edge to the next entry.
  - out_data holds stable while out_valid & !out_ready.
  - out_data while out_valid=0 is don't-care; the implementation holds its last value.
- Full FIFO (count==DEPTH):
  - A push with no pop on the same edge is dropped; `dropped` increments and saturates at 2^N-1. FIFO contents are unchanged.
  - A push with a simultaneous pop is accepted; count stays at DEPTH.
- Empty FIFO (count==0): out_ready is ignored and no pop occurs. A push and out_ready on the same edge do not bypass; the data appears next cycle.
- Pointers: log2(DEPTH) bits, wrap modulo DEPTH. count = push_accepted − pop, computed on every edge.
- Halt on the first HALT_ADDR store:
  - done becomes 1 one edge later; exit_code latches writedata.
  - Later halt stores are ignored, and done stays 1 until reset.
  - Capture continues after done.
- Address overlap: if CAPTURE_ADDR == HALT_ADDR, the store both pushes and halts.
- Other stores: non-matching stores and memwrite=0 cycles have no effect.

Optional Feature:
- Macro: STORE_CAPTURE_TIMESTAMP_EN.
- Defined:
  - A free-running N-bit cycle counter is added: reset 0, increments every cycle, wraps at 2^N.
  - Each FIFO entry also stores the counter value at push time.
  - Extra port `out_time out N` is presented alongside out_data under the same handshake.
  - A halt also latches `halt_time out N`; reset value 0.
- Undefined: no counter, no timestamp storage, and out_time/halt_time do not exist.

Decomposition:
- Package `store_capture_pkg`:
  - Defaults for N, DEPTH, CAPTURE_ADDR, HALT_ADDR.
  - typedef `capture_entry_t`, a struct of data plus time when the macro is defined.
- Sub-module `store_fifo`: synchronous FIFO with push/pop/full/empty/count, parameterised on entry type and DEPTH.
- Top level owns address decode, the drop counter, halt latch and timestamp counter.

Test Plan:
- Reset then 3 stores (0x0040←0x0096, 0x0040←0x1234, 0x0040←0xBEEF) with out_ready=1 → out_data sequence 0x0096, 0x1234, 0xBEEF, each one cycle after its store; count returns to 0; dropped=0.
- out_ready=0; 10 stores of 0..9 to 0x0040 (DEPTH=8) → count=8, dropped=2; after raising out_ready, drain yields 0..7 in order.
- Full FIFO, push 0xAAAA with out_ready=1 on the same edge → accepted, count stays 8, dropped unchanged, 0xAAAA emerges last.
- Store 0x0096 to 0x0044, and a store with memwrite=0 to 0x0040 → no push, count=0, out_valid=0.
- Store 0x0007 to 0x00FE, then 0x0009 to 0x00FE → done=1 one edge after the first; exit_code=0x0007.
- Assert reset with FIFO holding 5 entries and done=1, a capture store present the same cycle → next cycle: count=0, out_valid=0, done=0, dropped=0. With the macro defined, the first push after reset at cycle 3 gives out_time=3.
